alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Port clk  in  1  single clock; all state updates on rising edge.
REQ-002 Port reset  in  1  synchronous, active-high reset.
REQ-003 Ports in_valid/in_ready  in/out  1/1  upstream decode handshake; transfer when both high at a rising edge.
REQ-004 Ports opcode[6:0], funct3[2:0], funct7[6:0]  in  RV64 instruction fields; sampled only on transfer.
REQ-005 Ports rs1_val[63:0], rs2_val[63:0], imm[63:0]  in  operand values; sampled only on transfer.
REQ-006 Ports alu_a[63:0], alu_b[63:0], ALUOp[3:0]  out  registered drive to the 64-bit ALU.
REQ-007 Ports alu_result[63:0], alu_zero  in  combinational ALU response.
REQ-008 Ports out_valid/out_ready  out/in  1/1  downstream result handshake.
REQ-009 Ports out_result[63:0], out_taken, out_illegal  out  captured result, branch decision, illegal-decode flag.

Function
REQ-010 The FSM SHALL have states IDLE, EXEC and DONE; in_ready = 1 only in IDLE with reset low.
REQ-011 IDLE: on transfer, latch the decoded ALUOp, alu_a and alu_b and go to EXEC; otherwise hold.
REQ-012 EXEC: last one cycle; at its closing edge capture alu_result/alu_zero into out_result/out_taken and go to DONE.
REQ-013 DONE: out_valid = 1, outputs stable until out_ready = 1, then go to IDLE at that edge.
REQ-014 Latency: transfer at edge N -> out_valid high from edge N+2; max throughput one op per 3 cycles.
REQ-015 ALUOp encoding: AND 0000, OR 0001, ADD 0010, SUB 0110, SLL 1000, illegal 1111.
REQ-016 R-type (0110011): f3 000/f7 0000000 ADD; f3 000/f7 0100000 SUB; f3 001/f7 0 SLL; f3 110/f7 0 OR; f3 111/f7 0 AND; alu_a = rs1_val; alu_b = rs2_val.
REQ-017 I-type (0010011): f3 000 ADDI; 110 ORI; 111 ANDI (alu_b = imm); f3 001 with funct7[6:1] = 0 SLLI.
REQ-018 Shifts: alu_b = {58'b0, shamt[5:0]}, shamt = rs2_val[5:0] (SLL) or imm[5:0] (SLLI).
REQ-019 Load (0000011) and store (0100011): ADD, alu_a = rs1_val, alu_b = imm.
REQ-020 Any other opcode/funct combination: ALUOp = 1111, out_illegal = 1, out_result = 0, out_taken = 0; the handshake completes normally.
REQ-021 out_taken = 0 for all non-branch ops.
REQ-022 Arithmetic wraps modulo 2^64; no overflow flag.

Reset
REQ-023 While reset is high at an edge: state becomes IDLE; ALUOp, alu_a, alu_b, out_result, out_taken, out_illegal, out_valid become 0.
REQ-024 in_ready SHALL be 0 in any cycle where reset is high.
REQ-025 Reset in EXEC or DONE SHALL discard the in-flight op; no out_valid follows for it.
REQ-026 Reset dominates simultaneous in_valid or out_ready.

Configuration
REQ-027 Macro ALU_CTRL_BRANCH_EN SHALL gate branch support.
REQ-028 With ALU_CTRL_BRANCH_EN: opcode 1100011 f3 000 (BEQ) -> SUB on rs1_val, rs2_val, out_taken = alu_zero; f3 001 (BNE) -> SUB, out_taken = ~alu_zero; out_result = SUB result; other f3 values are illegal.
REQ-029 Without ALU_CTRL_BRANCH_EN: opcode 1100011 is illegal per REQ-020; no branch logic is synthesized.

Verification
REQ-030 ADD: rs1=5, rs2=7, f3=000, f7=0 -> ALUOp=0010 in EXEC; out_result=12, out_valid at N+2.
REQ-031 SUB/SLL: rs1=3, rs2=5, f7=0100000 -> out_result=0xFFFF_FFFF_FFFF_FFFE; SLL with rs1=1, rs2=0x41 -> alu_b=1, out_result=2.
REQ-032 Branch (macro on): BEQ rs1=rs2=9 -> out_taken=1, out_result=0; BNE same -> out_taken=0; macro off -> out_illegal=1.
REQ-033 Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_* stable, in_ready=0; release -> IDLE at the next edge.
REQ-034 Illegal: opcode 1111111 -> ALUOp=1111, out_illegal=1, out_result=0, handshake completes.
REQ-035 Reset in EXEC -> next cycle IDLE, all outputs 0, no out_valid for the dropped op.

Source files
------------

// File: rtl/alu_ctrl.sv
// Decode/sequencing controller for an external 64-bit ALU: IDLE -> EXEC -> DONE per op.
// Define ALU_CTRL_BRANCH_EN to add BEQ/BNE decode and branch-taken evaluation.
module alu_ctrl #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [DATA_W-1:0] rs1_val,
  input  logic [DATA_W-1:0] rs2_val,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        ALUOp,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_taken,
  output logic              out_illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_ILL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]        w_aluop;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic              w_ill;
  logic              w_br;
  logic              w_bne;

  logic [3:0]        r_aluop_p0;
  logic [DATA_W-1:0] r_alu_a_p0;
  logic [DATA_W-1:0] r_alu_b_p0;
  logic              r_ill_p0;
  logic [DATA_W-1:0] r_result_p1;
  logic              r_taken_p1;
  logic              r_ill_p1;

  // Instruction decode: anything not matched falls through as illegal with zero operands.
  always_comb begin
    w_aluop = OP_ILL;
    w_a     = '0;
    w_b     = '0;
    w_ill   = 1'b1;
    w_br    = 1'b0;
    w_bne   = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  begin w_aluop = OP_ADD; w_ill = 1'b0; end
            3'b001:  begin w_aluop = OP_SLL; w_ill = 1'b0; end
            3'b110:  begin w_aluop = OP_OR;  w_ill = 1'b0; end
            3'b111:  begin w_aluop = OP_AND; w_ill = 1'b0; end
            default: ;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          w_aluop = OP_SUB;
          w_ill   = 1'b0;
        end
        if (!w_ill) begin
          w_a = rs1_val;
          w_b = (w_aluop == OP_SLL) ? DATA_W'(rs2_val[5:0]) : rs2_val;
        end
      end
      7'b0010011: begin
        case (funct3)
          3'b000:  begin w_aluop = OP_ADD; w_ill = 1'b0; end
          3'b110:  begin w_aluop = OP_OR;  w_ill = 1'b0; end
          3'b111:  begin w_aluop = OP_AND; w_ill = 1'b0; end
          3'b001:  if (funct7[6:1] == 6'b0) begin w_aluop = OP_SLL; w_ill = 1'b0; end
          default: ;
        endcase
        if (!w_ill) begin
          w_a = rs1_val;
          w_b = (w_aluop == OP_SLL) ? DATA_W'(imm[5:0]) : imm;
        end
      end
      7'b0000011, 7'b0100011: begin
        w_aluop = OP_ADD;
        w_ill   = 1'b0;
        w_a     = rs1_val;
        w_b     = imm;
      end
`ifdef ALU_CTRL_BRANCH_EN
      7'b1100011: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          w_aluop = OP_SUB;
          w_ill   = 1'b0;
          w_br    = 1'b1;
          w_bne   = funct3[0];
          w_a     = rs1_val;
          w_b     = rs2_val;
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

`ifdef ALU_CTRL_BRANCH_EN
  logic r_br_p0;
  logic r_bne_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_br_p0  <= 1'b0;
      r_bne_p0 <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_br_p0  <= w_br;
      r_bne_p0 <= w_bne;
    end
  end
`else
  logic w_unused_br;
  assign w_unused_br = w_br ^ w_bne ^ alu_zero;
`endif

  // Stage p0: operands latched on transfer; stage p1: ALU response captured as EXEC closes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_aluop_p0  <= 4'b0000;
      r_alu_a_p0  <= '0;
      r_alu_b_p0  <= '0;
      r_ill_p0    <= 1'b0;
      r_result_p1 <= '0;
      r_taken_p1  <= 1'b0;
      r_ill_p1    <= 1'b0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_aluop_p0 <= w_aluop;
        r_alu_a_p0 <= w_a;
        r_alu_b_p0 <= w_b;
        r_ill_p0   <= w_ill;
      end
      if (r_state == EXEC) begin
        r_result_p1 <= r_ill_p0 ? '0 : alu_result;
        r_ill_p1    <= r_ill_p0;
`ifdef ALU_CTRL_BRANCH_EN
        r_taken_p1  <= r_br_p0 && (r_bne_p0 ? !alu_zero : alu_zero);
`else
        r_taken_p1  <= 1'b0;
`endif
      end
    end
  end

  assign in_ready    = (r_state == IDLE) && !reset;
  assign out_valid   = (r_state == DONE);
  assign ALUOp       = r_aluop_p0;
  assign alu_a       = r_alu_a_p0;
  assign alu_b       = r_alu_b_p0;
  assign out_result  = r_result_p1;
  assign out_taken   = r_taken_p1;
  assign out_illegal = r_ill_p1;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural 64-bit ALU attached to its ALU port.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] rs1_val;
  logic [63:0] rs2_val;
  logic [63:0] imm;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  ALUOp;
  logic [63:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_taken;
  logic        out_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .alu_a(alu_a), .alu_b(alu_b), .ALUOp(ALUOp),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_taken(out_taken), .out_illegal(out_illegal)
  );

  // Behavioural ALU seen by the controller.
  always_comb begin
    case (ALUOp)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b1000: alu_result = alu_a << alu_b[5:0];
      default: alu_result = 64'd0;
    endcase
  end
  assign alu_zero = (alu_result == 64'd0);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [63:0] r1, input logic [63:0] r2,
                        input logic [63:0] im, input logic [3:0] e_op, input logic [63:0] e_a,
                        input logic [63:0] e_b, input logic [63:0] e_res, input logic e_tk,
                        input logic e_ill, input int hold);
    opcode = op; funct3 = f3; funct7 = f7;
    rs1_val = r1; rs2_val = r2; imm = im;
    in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, ".in_ready_idle"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    opcode = 7'h7f; funct3 = 3'h7; funct7 = 7'h7f;
    rs1_val = ~r1; rs2_val = ~r2; imm = ~im;
    chk({tag, ".aluop"}, ALUOp, e_op);
    chk({tag, ".alu_a"}, alu_a, e_a);
    chk({tag, ".alu_b"}, alu_b, e_b);
    chk({tag, ".out_valid_exec"}, out_valid, 1'b0);
    tick();
    chk({tag, ".out_valid_done"}, out_valid, 1'b1);
    chk({tag, ".result"}, out_result, e_res);
    chk({tag, ".taken"}, out_taken, e_tk);
    chk({tag, ".illegal"}, out_illegal, e_ill);
    chk({tag, ".in_ready_done"}, in_ready, 1'b0);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({tag, ".hold_valid"}, out_valid, 1'b1);
      chk({tag, ".hold_result"}, out_result, e_res);
      chk({tag, ".hold_illegal"}, out_illegal, e_ill);
      chk({tag, ".hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".out_valid_idle"}, out_valid, 1'b0);
    chk({tag, ".in_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0;
    rs1_val = 64'd5; rs2_val = 64'd7; imm = 64'd0;
    tick();
    tick();
    chk("rst.in_ready", in_ready, 1'b0);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.aluop", ALUOp, 4'b0000);
    chk("rst.alu_a", alu_a, 64'd0);
    chk("rst.alu_b", alu_b, 64'd0);
    chk("rst.result", out_result, 64'd0);
    chk("rst.taken", out_taken, 1'b0);
    chk("rst.illegal", out_illegal, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst.release_in_ready", in_ready, 1'b1);

    run_op("add", 7'b0110011, 3'b000, 7'b0000000, 64'd5, 64'd7, 64'd0,
           4'b0010, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 0);
    run_op("sub", 7'b0110011, 3'b000, 7'b0100000, 64'd3, 64'd5, 64'd0,
           4'b0110, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0);
    run_op("sll", 7'b0110011, 3'b001, 7'b0000000, 64'd1, 64'h41, 64'd0,
           4'b1000, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0, 0);
    run_op("or", 7'b0110011, 3'b110, 7'b0000000, 64'hF0, 64'h0F, 64'd0,
           4'b0001, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 0);
    run_op("and", 7'b0110011, 3'b111, 7'b0000000, 64'hFF, 64'h3C, 64'd0,
           4'b0000, 64'hFF, 64'h3C, 64'h3C, 1'b0, 1'b0, 0);
    run_op("add_wrap", 7'b0110011, 3'b000, 7'b0000000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0,
           4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b0, 0);
    run_op("addi", 7'b0010011, 3'b000, 7'b0000000, 64'd10, 64'd99, 64'hFFFF_FFFF_FFFF_FFFD,
           4'b0010, 64'd10, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b0, 1'b0, 0);
    run_op("slli", 7'b0010011, 3'b001, 7'b0000001, 64'd1, 64'd0, 64'h23,
           4'b1000, 64'd1, 64'h23, 64'h8_0000_0000, 1'b0, 1'b0, 0);
    run_op("load", 7'b0000011, 3'b011, 7'b0000000, 64'h1000, 64'd0, 64'h20,
           4'b0010, 64'h1000, 64'h20, 64'h1020, 1'b0, 1'b0, 0);
    run_op("store_bp", 7'b0100011, 3'b011, 7'b0000000, 64'h2000, 64'h55, 64'h8,
           4'b0010, 64'h2000, 64'h8, 64'h2008, 1'b0, 1'b0, 5);
    run_op("r_bad_f7", 7'b0110011, 3'b111, 7'b0100000, 64'd4, 64'd6, 64'd0,
           4'b1111, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 0);
`ifdef ALU_CTRL_BRANCH_EN
    run_op("beq", 7'b1100011, 3'b000, 7'b0000000, 64'd9, 64'd9, 64'd0,
           4'b0110, 64'd9, 64'd9, 64'd0, 1'b1, 1'b0, 0);
    run_op("bne", 7'b1100011, 3'b001, 7'b0000000, 64'd9, 64'd9, 64'd0,
           4'b0110, 64'd9, 64'd9, 64'd0, 1'b0, 1'b0, 0);
    run_op("bne_diff", 7'b1100011, 3'b001, 7'b0000000, 64'd9, 64'd4, 64'd0,
           4'b0110, 64'd9, 64'd4, 64'd5, 1'b1, 1'b0, 0);
`else
    run_op("beq_off", 7'b1100011, 3'b000, 7'b0000000, 64'd9, 64'd9, 64'd0,
           4'b1111, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 0);
`endif
    run_op("illegal", 7'b1111111, 3'b000, 7'b0000000, 64'd3, 64'd4, 64'd5,
           4'b1111, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 0);

    // Launch an ADD, then reset while it sits in EXEC.
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0;
    rs1_val = 64'd20; rs2_val = 64'd22; imm = 64'd0;
    in_valid = 1'b1;
    tick();
    chk("rexec.aluop_before", ALUOp, 4'b0010);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("rexec.in_ready_rst", in_ready, 1'b0);
    tick();
    chk("rexec.out_valid", out_valid, 1'b0);
    chk("rexec.aluop", ALUOp, 4'b0000);
    chk("rexec.alu_a", alu_a, 64'd0);
    chk("rexec.alu_b", alu_b, 64'd0);
    chk("rexec.result", out_result, 64'd0);
    chk("rexec.illegal", out_illegal, 1'b0);
    chk("rexec.taken", out_taken, 1'b0);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rexec.in_ready_idle", in_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rexec.no_valid", out_valid, 1'b0);
      chk("rexec.stay_idle", in_ready, 1'b1);
    end

    run_op("post_rst", 7'b0110011, 3'b000, 7'b0000000, 64'd20, 64'd22, 64'd0,
           4'b0010, 64'd20, 64'd22, 64'd42, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
